// File: rtl/regfile_layer_cfg.sv
// ---------------------------------------------------------------------------
// regfile_layer_cfg
//
// Layer-configuration register bank for the conv/pool engines, sitting on the
// reg_intf bus. The host writes configuration into staging (shadow) registers.
// The engine only ever sees the active copy. The staging bank is copied into
// the active bank atomically on COMMIT, and only while the engine is idle.
// The block also provides:
//   - a one-cycle START pulse,
//   - sticky write-1-to-clear event flags with a registered interrupt,
//   - registered bus reads.
//
// Address map (offsets from BASE_ADDR):
//   0                       CTRL      write-only, reads 0; bit0 START, bit1 COMMIT
//   1 .. NUM_CFG            CFG_i     staging registers, RW
//   1+NUM_CFG ..            STAT_j    live status_in, RO
//   A = 1+NUM_CFG+NUM_STAT  IRQ_STAT  W1C; bit0 DONE, bit1 ERR, bit2 START_OVR
//   A+1                     IRQ_EN    RW, bits[2:0]
//   All other addresses ignore writes and read as 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, rd_en    bus write / read strobes
//   addr            bus address
//   write_data      bus write data
//   read_data       registered read data (holds between reads)
//   read_valid      one-cycle flag, asserted the cycle after rd_en
//   cfg_active      active configuration; CFG_i at [i*DATA_W +: DATA_W]
//   start_pulse     one-cycle engine start
//   commit_pending  COMMIT has been requested but not yet applied
//   busy            engine running; holds off COMMIT and START
//   done_evt        engine done event (sets IRQ_STAT.DONE)
//   err_evt         engine error event (sets IRQ_STAT.ERR)
//   status_in       live engine status words, read through STAT_j
//   irq             registered OR of IRQ_STAT & IRQ_EN
// ---------------------------------------------------------------------------
module regfile_layer_cfg #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h100,
  parameter int                NUM_CFG   = 16,
  parameter int                NUM_STAT  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            write_data,
  output logic [DATA_W-1:0]            read_data,
  output logic                         read_valid,
  output logic [NUM_CFG*DATA_W-1:0]    cfg_active,
  output logic                         start_pulse,
  output logic                         commit_pending,
  input  logic                         busy,
  input  logic                         done_evt,
  input  logic                         err_evt,
  input  logic [NUM_STAT*DATA_W-1:0]   status_in,
  output logic                         irq
);

  localparam int CFG_OFF      = 1;
  localparam int STAT_OFF     = 1 + NUM_CFG;
  localparam int IRQ_STAT_OFF = 1 + NUM_CFG + NUM_STAT;
  localparam int IRQ_EN_OFF   = IRQ_STAT_OFF + 1;
  localparam int STAT_SLOTS   = (NUM_STAT > 0) ? NUM_STAT : 1;

  logic [DATA_W-1:0] cfg_stage [NUM_CFG];
  logic [2:0]        irq_stat;
  logic [2:0]        irq_en;

  logic              in_range;
  logic [ADDR_W-1:0] off;
  logic              sel_ctrl;
  logic              sel_irq_stat;
  logic              sel_irq_en;
  logic [NUM_CFG-1:0]    sel_cfg;
  logic [STAT_SLOTS-1:0] sel_stat;

  logic              wr_start;
  logic              wr_commit;
  logic              do_copy;
  logic [2:0]        irq_set;
  logic [2:0]        irq_clr;
  logic [2:0]        irq_stat_next;
  logic [DATA_W-1:0] rd_mux;

  // Addresses below BASE_ADDR must not alias onto the map through wrap-around.
  assign in_range = (addr >= BASE_ADDR);
  assign off      = addr - BASE_ADDR;

  // One-hot register select decoded from the offset.
  always_comb begin
    sel_ctrl     = in_range && (off == ADDR_W'(0));
    sel_irq_stat = in_range && (off == ADDR_W'(IRQ_STAT_OFF));
    sel_irq_en   = in_range && (off == ADDR_W'(IRQ_EN_OFF));
    sel_cfg      = '0;
    sel_stat     = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      sel_cfg[i] = in_range && (off == ADDR_W'(CFG_OFF + i));
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      sel_stat[j] = in_range && (off == ADDR_W'(STAT_OFF + j));
    end
  end

  // CTRL strobes. A START that also carries COMMIT, or that finds a commit
  // already pending, copies at the same edge that launches start_pulse, so
  // the engine never starts on stale configuration.
  assign wr_start  = wr_en && sel_ctrl && write_data[0];
  assign wr_commit = wr_en && sel_ctrl && write_data[1];
  assign do_copy   = !busy && (commit_pending || (wr_start && wr_commit));

  // Hardware sets are ORed in after the W1C mask, so a set wins over a
  // simultaneous clear.
  assign irq_set       = {wr_start && busy, err_evt, done_evt};
  assign irq_clr       = (wr_en && sel_irq_stat) ? write_data[2:0] : 3'b000;
  assign irq_stat_next = (irq_stat & ~irq_clr) | irq_set;

  // Read multiplexer. It works on current register contents, so a write and
  // a read to the same address in one cycle return the pre-write value.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (sel_cfg[i]) rd_mux = cfg_stage[i];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (sel_stat[j]) rd_mux = status_in[j*DATA_W +: DATA_W];
    end
    if (sel_irq_stat) rd_mux = {{(DATA_W-3){1'b0}}, irq_stat};
    if (sel_irq_en)   rd_mux = {{(DATA_W-3){1'b0}}, irq_en};
  end

  // All architectural state. Reset discards any pending COMMIT or START.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_stage[i] <= '0;
      cfg_active     <= '0;
      commit_pending <= 1'b0;
      start_pulse    <= 1'b0;
      irq_stat       <= 3'b000;
      irq_en         <= 3'b000;
      irq            <= 1'b0;
      read_data      <= '0;
      read_valid     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (wr_en && sel_cfg[i]) cfg_stage[i] <= write_data;
      end

      // The copy takes the staging contents from before any same-cycle write.
      // A COMMIT that arrives while one is already pending is absorbed.
      if (do_copy) begin
        for (int i = 0; i < NUM_CFG; i++) begin
          cfg_active[i*DATA_W +: DATA_W] <= cfg_stage[i];
        end
        commit_pending <= 1'b0;
      end else if (wr_commit) begin
        commit_pending <= 1'b1;
      end

      start_pulse <= wr_start && !busy;

      irq_stat <= irq_stat_next;
      if (wr_en && sel_irq_en) irq_en <= write_data[2:0];
      irq <= |(irq_stat & irq_en);

      read_valid <= rd_en;
      if (rd_en) read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_regfile_layer_cfg.sv
module tb_regfile_layer_cfg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 14;
  localparam int NUM_CFG  = 16;
  localparam int NUM_STAT = 4;
  localparam int CW       = NUM_CFG * DATA_W;
  localparam int SW       = NUM_STAT * DATA_W;

  localparam logic [13:0] A_CTRL  = 14'h100;
  localparam logic [13:0] A_CFG0  = 14'h101;
  localparam logic [13:0] A_STAT0 = 14'h111;
  localparam logic [13:0] A_IRQS  = 14'h115;
  localparam logic [13:0] A_IRQE  = 14'h116;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [13:0]   addr;
  logic [15:0]   write_data;
  logic [15:0]   read_data;
  logic          read_valid;
  logic [CW-1:0] cfg_active;
  logic          start_pulse;
  logic          commit_pending;
  logic          busy;
  logic          done_evt;
  logic          err_evt;
  logic [SW-1:0] status_in;
  logic          irq;

  int n_checks;
  int n_fail;

  regfile_layer_cfg #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(A_CTRL),
    .NUM_CFG  (NUM_CFG),
    .NUM_STAT (NUM_STAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .addr          (addr),
    .write_data    (write_data),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .cfg_active    (cfg_active),
    .start_pulse   (start_pulse),
    .commit_pending(commit_pending),
    .busy          (busy),
    .done_evt      (done_evt),
    .err_evt       (err_evt),
    .status_in     (status_in),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It keeps the register file as plain arrays and decodes
  // addresses arithmetically from the offset.
  logic [15:0]   m_stage [NUM_CFG];
  logic [CW-1:0] m_active;
  logic          m_pend;
  logic          m_sp;
  logic          m_irq;
  logic          m_rv;
  logic [15:0]   m_rd;
  logic [2:0]    m_is;
  logic [2:0]    m_ie;

  logic m_start_w;
  logic m_commit_w;
  logic [2:0] m_clr;
  int   m_cfg_idx;

  assign m_start_w  = wr_en && (addr == A_CTRL) && write_data[0];
  assign m_commit_w = wr_en && (addr == A_CTRL) && write_data[1];
  assign m_clr      = (wr_en && addr == A_IRQS) ? write_data[2:0] : 3'b000;
  assign m_cfg_idx  = int'(addr) - int'(A_CFG0);

  function automatic logic [15:0] model_read(input logic [13:0] a, input logic [SW-1:0] st);
    int o;
    o = int'(a) - int'(A_CTRL);
    if (o >= 1 && o <= NUM_CFG) return m_stage[o-1];
    if (o > NUM_CFG && o <= NUM_CFG + NUM_STAT) return st[(o-1-NUM_CFG)*16 +: 16];
    if (o == NUM_CFG + NUM_STAT + 1) return {13'b0, m_is};
    if (o == NUM_CFG + NUM_STAT + 2) return {13'b0, m_ie};
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CFG; k++) m_stage[k] <= 16'h0000;
      m_active <= '0;
      m_pend   <= 1'b0;
      m_sp     <= 1'b0;
      m_irq    <= 1'b0;
      m_rv     <= 1'b0;
      m_rd     <= 16'h0000;
      m_is     <= 3'b000;
      m_ie     <= 3'b000;
    end else begin
      m_rv <= rd_en;
      if (rd_en) m_rd <= model_read(addr, status_in);
      m_irq <= |(m_is & m_ie);
      m_sp  <= m_start_w && !busy;
      if (!busy && (m_pend || (m_start_w && m_commit_w))) begin
        for (int k = 0; k < NUM_CFG; k++) m_active[k*16 +: 16] <= m_stage[k];
        m_pend <= 1'b0;
      end else if (m_commit_w) begin
        m_pend <= 1'b1;
      end
      m_is <= (m_is & ~m_clr) | {m_start_w && busy, err_evt, done_evt};
      if (wr_en && addr == A_IRQE) m_ie <= write_data[2:0];
      if (wr_en && m_cfg_idx >= 0 && m_cfg_idx < NUM_CFG) m_stage[m_cfg_idx] <= write_data;
    end
  end

  // Drive one bus cycle, then release the strobes just after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [13:0] a,
                               input logic [15:0] d);
    wr_en      = w;
    rd_en      = r;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [CW-1:0] act,
                             input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [13:0]   addr;
    logic [SW-1:0] status;
    logic [15:0]   exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  initial begin
    rd_vec_t v;
    logic [SW-1:0] pattern;
    int r;

    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    addr       = '0;
    write_data = '0;
    busy       = 1'b0;
    done_evt   = 1'b0;
    err_evt    = 1'b0;
    status_in  = '0;

    // Read-after-reset table: every mapped address plus two unmapped ones.
    pattern = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int a = 16'h100; a <= 16'h116; a++) begin
      v.addr   = 14'(a);
      v.status = '0;
      v.exp    = 16'h0000;
      vecs.push_back(v);
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      v.addr   = A_STAT0 + 14'(j);
      v.status = pattern;
      v.exp    = 16'(16'h1111 * (j + 1));
      vecs.push_back(v);
    end
    v.addr = 14'h3FFF; v.status = pattern; v.exp = 16'h0000; vecs.push_back(v);
    v.addr = 14'h00FF; v.status = pattern; v.exp = 16'h0000; vecs.push_back(v);

    idleCycles(2);
    rst = 1'b0;
    checkOutput("reset cfg_active", cfg_active, '0);
    checkOutput("reset start_pulse", CW'(start_pulse), '0);
    checkOutput("reset commit_pending", CW'(commit_pending), '0);
    checkOutput("reset irq", CW'(irq), '0);
    checkOutput("reset read_valid", CW'(read_valid), '0);
    checkOutput("reset read_data", CW'(read_data), '0);

    foreach (vecs[i]) begin
      status_in = vecs[i].status;
      applyStimulus(1'b0, 1'b1, vecs[i].addr, 16'h0000);
      checkOutput($sformatf("rd valid @%0h", vecs[i].addr), CW'(read_valid), CW'(1));
      checkOutput($sformatf("rd data @%0h", vecs[i].addr), CW'(read_data), CW'(vecs[i].exp));
      status_in = ~vecs[i].status;
      idleCycles(1);
      checkOutput($sformatf("rd valid drop @%0h", vecs[i].addr), CW'(read_valid), '0);
      checkOutput($sformatf("rd data hold @%0h", vecs[i].addr), CW'(read_data), CW'(vecs[i].exp));
    end
    status_in = '0;

    // COMMIT while idle.
    applyStimulus(1'b1, 1'b0, A_CFG0, 16'hA5A5);
    applyStimulus(1'b1, 1'b0, A_CTRL, 16'h0002);
    checkOutput("idle commit pending set", CW'(commit_pending), CW'(1));
    checkOutput("idle commit not yet copied", CW'(cfg_active[15:0]), '0);
    idleCycles(1);
    checkOutput("idle commit copied", CW'(cfg_active[15:0]), CW'(16'hA5A5));
    checkOutput("idle commit pending clear", CW'(commit_pending), '0);

    // COMMIT while busy waits for busy to drop.
    busy = 1'b1;
    applyStimulus(1'b1, 1'b0, A_CFG0 + 14'd1, 16'h0003);
    applyStimulus(1'b1, 1'b0, A_CTRL, 16'h0002);
    idleCycles(2);
    checkOutput("busy commit pending", CW'(commit_pending), CW'(1));
    checkOutput("busy commit cfg1 held", CW'(cfg_active[31:16]), '0);
    checkOutput("busy commit cfg0 held", CW'(cfg_active[15:0]), CW'(16'hA5A5));
    busy = 1'b0;
    idleCycles(1);
    checkOutput("busy drop copies cfg1", CW'(cfg_active[31:16]), CW'(16'h0003));
    checkOutput("busy drop pending clear", CW'(commit_pending), '0);

    // START+COMMIT with stale active config, then START while busy.
    applyStimulus(1'b1, 1'b0, A_CFG0 + 14'd2, 16'h1234);
    applyStimulus(1'b1, 1'b0, A_CTRL, 16'h0003);
    checkOutput("start pulse", CW'(start_pulse), CW'(1));
    checkOutput("start cfg already new", CW'(cfg_active[47:32]), CW'(16'h1234));
    checkOutput("start pending clear", CW'(commit_pending), '0);
    idleCycles(1);
    checkOutput("start pulse one cycle", CW'(start_pulse), '0);
    busy = 1'b1;
    applyStimulus(1'b1, 1'b0, A_CTRL, 16'h0001);
    checkOutput("busy start no pulse", CW'(start_pulse), '0);
    applyStimulus(1'b0, 1'b1, A_IRQS, 16'h0000);
    checkOutput("start overrun flag", CW'(read_data), CW'(16'h0004));
    busy = 1'b0;
    applyStimulus(1'b1, 1'b0, A_IRQS, 16'h0007);

    // Interrupt flow: set, set-beats-clear, clear, irq latency.
    applyStimulus(1'b1, 1'b0, A_IRQE, 16'h0001);
    done_evt = 1'b1;
    idleCycles(1);
    done_evt = 1'b0;
    checkOutput("irq latency", CW'(irq), '0);
    idleCycles(1);
    checkOutput("irq raised", CW'(irq), CW'(1));
    applyStimulus(1'b0, 1'b1, A_IRQS, 16'h0000);
    checkOutput("irq_stat done", CW'(read_data), CW'(16'h0001));
    done_evt = 1'b1;
    applyStimulus(1'b1, 1'b0, A_IRQS, 16'h0001);
    done_evt = 1'b0;
    applyStimulus(1'b0, 1'b1, A_IRQS, 16'h0000);
    checkOutput("set wins over w1c", CW'(read_data), CW'(16'h0001));
    checkOutput("irq kept", CW'(irq), CW'(1));
    applyStimulus(1'b1, 1'b0, A_IRQS, 16'h0001);
    checkOutput("irq drop latency", CW'(irq), CW'(1));
    idleCycles(1);
    checkOutput("irq dropped", CW'(irq), '0);

    // Reset with a commit pending while busy.
    busy = 1'b1;
    applyStimulus(1'b1, 1'b0, A_CFG0 + 14'd3, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, A_CTRL, 16'h0002);
    checkOutput("pre-reset pending", CW'(commit_pending), CW'(1));
    applyStimulus(1'b0, 1'b1, A_CFG0, 16'h0000);
    checkOutput("pre-reset read", CW'(read_data), CW'(16'hA5A5));
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("mid reset cfg_active", cfg_active, '0);
    checkOutput("mid reset pending", CW'(commit_pending), '0);
    checkOutput("mid reset start", CW'(start_pulse), '0);
    checkOutput("mid reset irq", CW'(irq), '0);
    checkOutput("mid reset read_valid", CW'(read_valid), '0);
    checkOutput("mid reset read_data", CW'(read_data), '0);
    busy = 1'b0;
    idleCycles(3);
    checkOutput("no copy after reset", cfg_active, '0);
    checkOutput("no pending after reset", CW'(commit_pending), '0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      rd_en      = ($urandom_range(0, 1) == 0);
      r          = $urandom_range(0, 24);
      if (r == 23)      addr = 14'h3FFF;
      else if (r == 24) addr = 14'h00FF;
      else              addr = A_CTRL + 14'(r);
      write_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) busy = ~busy;
      done_evt   = ($urandom_range(0, 5) == 0);
      err_evt    = ($urandom_range(0, 5) == 0);
      status_in  = {$urandom, $urandom};
      @(posedge clk);
      #1;
      checkOutput("rnd read_valid", CW'(read_valid), CW'(m_rv));
      checkOutput("rnd read_data", CW'(read_data), CW'(m_rd));
      checkOutput("rnd cfg_active", cfg_active, m_active);
      checkOutput("rnd start_pulse", CW'(start_pulse), CW'(m_sp));
      checkOutput("rnd commit_pending", CW'(commit_pending), CW'(m_pend));
      checkOutput("rnd irq", CW'(irq), CW'(m_irq));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
